sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Target-side endpoint of the cache-to-SDRAM request protocol (ready/request/addr/write/burst/wstrb/wdata → rvalid/rdata/raddress/complete).
- Serves a single initiator, such as the data cache, from an on-chip word-addressed memory with configurable read latency.
- Two uses: the on-chip RAM region in FPGA builds, and the reference memory model in cache-level test benches.
- Implements single writes, single reads and 16-beat wrapping line bursts.

Parameters:
- ADDR_WIDTH, 26, byte address width of the request port.
- MEM_WORDS, 16384, depth of backing memory in 32-bit words; power of two.
- READ_LATENCY, 3, cycles from request acceptance to first read beat; legal range 1..15.
- BURST_LEN, 16, beats per burst; fixed to one 64-byte line.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- dcache_sdram_ready  output  1  responder will accept a request presented this cycle.
- dcache_sdram_request  input  1  initiator request valid.
- dcache_sdram_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
- dcache_sdram_write  input  1  1 = write, 0 = read.
- dcache_sdram_burst  input  1  1 = 16-beat read burst, 0 = single.
- dcache_sdram_wstrb  input  4  byte enables for writes.
- dcache_sdram_wdata  input  32  write data.
- dcache_sdram_rvalid  output  1  read beat valid.
- dcache_sdram_rdata  output  32  read beat data.
- dcache_sdram_raddress  output  ADDR_WIDTH  word-aligned address of the current beat; [1:0] = 0.
- dcache_sdram_complete  output  1  final beat of the transaction.

Behaviour:
Reset
- While reset = 0, immediately force: state IDLE, ready = 0, rvalid = 0, complete = 0, rdata = 0, raddress = 0, counters = 0.
- Memory contents are not cleared.
- ready rises on the first posedge after reset releases.

Acceptance and address mapping
- A request is accepted at a posedge where request && ready. All outputs are registered.
- Memory index = addr[log2(MEM_WORDS)+1 : 2]. Higher address bits alias.

States: IDLE, WAIT, BURST.

IDLE (ready = 1)
- Accepted write: byte-masked write to memory at that edge, per wstrb bit. Stay in IDLE; ready stays 1, so back-to-back writes run at one per cycle.
- write = 1 with burst = 1: treated as a single write.
- wstrb = 0: no change to memory.
- No rvalid is ever produced for a write.
- Accepted read: latch addr (word-aligned) and burst. Load latency counter with READ_LATENCY-1. Beat counter = 0. ready → 0. Go to WAIT.

WAIT (ready = 0)
- Decrement the latency counter.
- At zero, go to BURST and present beat 0.
- First rvalid is high in the cycle READ_LATENCY cycles after the acceptance edge.
- READ_LATENCY = 1 means rvalid appears the cycle immediately after acceptance.

BURST (ready = 0)
- One beat per cycle; no gaps and no backpressure.
- Beat k: raddress = {addr[ADDR_WIDTH-1:6], (addr[5:2]+k) mod 16, 2'b00}. This is critical-word-first, wrapping within the 64-byte line. rdata = mem[raddress].
- Single read: one beat with complete = 1.
- Burst: beats k = 0..15; complete = 1 only on k = 15.
- The cycle after the complete beat: rvalid = 0, complete = 0, state IDLE, ready = 1. A new request can be accepted at the end of that cycle.

Other rules
- rdata and raddress hold their last values when rvalid = 0.
- Read-after-write: a read accepted on any edge after a write's acceptance edge returns the written data.
- A request present while ready = 0 is ignored. The initiator must hold it until ready.
- Reset asserted mid-WAIT or mid-BURST aborts the transaction asynchronously. No further beats and no complete are produced.

Test Plan:
- Reset release → ready 0 during reset, 1 one cycle after release. rvalid = 0 throughout.
- Write 0x1000 wdata = 0xAABBCCDD wstrb = 4'b1111, then write 0x1000 wdata = 0x11223344 wstrb = 4'b0101, then single read 0x1000 (READ_LATENCY = 3) → rvalid + complete exactly 3 cycles after acceptance. rdata = 0xAA22CC44. raddress = 0x1000. ready returns the next cycle.
- Preload words 0x2000..0x203C with their own addresses; burst read 0x2024 → 16 consecutive beats with raddress 0x2024, 0x2028, …, 0x203C, 0x2000, …, 0x2020. rdata = raddress on every beat. complete only on beat 16 (raddress 0x2020). ready = 0 from acceptance until the cycle after complete.
- Back-to-back writes on 4 consecutive cycles to 0x3000..0x300C with ready held 1 → all four words read back correct. A read issued on the cycle after the last write returns the new data.
- Reset asserted at burst beat 5 → rvalid/complete drop without a clock edge. No further beats after release. A fresh single read then returns correct data.
- Address aliasing with MEM_WORDS = 16384: write 0x0000010, read 0x0010010 → returns the written value.

Source files
------------

// File: rtl/sdram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdram_responder
// Description : Target-side endpoint of the cache-to-SDRAM request protocol.
//               Serves one initiator from an on-chip word-addressed memory.
//               Supports single byte-masked writes, single reads and 16-beat
//               critical-word-first wrapping line bursts, with a
//               configurable read latency.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock                  in   1    single clock, posedge
//   reset                  in   1    asynchronous active-low reset
//   dcache_sdram_ready     out  1    a request presented this cycle is taken
//   dcache_sdram_request   in   1    initiator request valid
//   dcache_sdram_addr      in   AW   byte address, [1:0] ignored
//   dcache_sdram_write     in   1    1 = write, 0 = read
//   dcache_sdram_burst     in   1    1 = 16-beat read burst, 0 = single
//   dcache_sdram_wstrb     in   4    write byte enables
//   dcache_sdram_wdata     in   32   write data
//   dcache_sdram_rvalid    out  1    read beat valid
//   dcache_sdram_rdata     out  32   read beat data
//   dcache_sdram_raddress  out  AW   word-aligned address of current beat
//   dcache_sdram_complete  out  1    final beat of the transaction
// ============================================================================
module sdram_responder #(
    parameter int ADDR_WIDTH   = 26,
    parameter int MEM_WORDS    = 16384,
    parameter int READ_LATENCY = 3,
    parameter int BURST_LEN    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  dcache_sdram_ready,
    input  logic                  dcache_sdram_request,
    input  logic [ADDR_WIDTH-1:0] dcache_sdram_addr,
    input  logic                  dcache_sdram_write,
    input  logic                  dcache_sdram_burst,
    input  logic [3:0]            dcache_sdram_wstrb,
    input  logic [31:0]           dcache_sdram_wdata,
    output logic                  dcache_sdram_rvalid,
    output logic [31:0]           dcache_sdram_rdata,
    output logic [ADDR_WIDTH-1:0] dcache_sdram_raddress,
    output logic                  dcache_sdram_complete
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Clears the byte-offset bits of an incoming address.
    localparam logic [ADDR_WIDTH-1:0] C_WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [3:0]            C_LAT_INIT  = 4'(READ_LATENCY - 1);
    localparam logic [3:0]            C_LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_rvalid;
    logic                  r_complete;
    logic [31:0]           r_rdata;
    logic [ADDR_WIDTH-1:0] r_raddress;
    logic [3:0]            r_lat_cnt;
    logic [3:0]            r_beat;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_burst;

    logic [31:0] r_mem [0:MEM_WORDS-1];

    logic                  w_accept;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [3:0]            w_beat_sel;
    logic [3:0]            w_beat_off;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [IDX_W-1:0]      w_beat_idx;

    // Ready is only ever high in IDLE, but qualify on state anyway.
    assign w_accept = r_ready && dcache_sdram_request && (r_state == S_IDLE);
    assign w_wr_idx = dcache_sdram_addr[IDX_W+1:2];

    // Beat about to be presented: beat 0 when leaving WAIT, else the next one.
    always_comb begin
        w_beat_sel = 4'd0;
        if (r_state == S_BURST) begin
            w_beat_sel = r_beat + 4'd1;
        end
    end

    // Critical-word-first: the word offset wraps inside the 64-byte line.
    // r_base[1:0] is always zero because of the mask applied on capture.
    assign w_beat_off  = r_base[5:2] + w_beat_sel;
    assign w_beat_addr = {r_base[ADDR_WIDTH-1:6], w_beat_off, r_base[1:0]};
    assign w_beat_idx  = w_beat_addr[IDX_W+1:2];

    // Backing store is deliberately not reset. Writes are only accepted in
    // IDLE, so they never collide with an outstanding read.
    always_ff @(posedge clock) begin
        if (w_accept && dcache_sdram_write) begin
            for (int i = 0; i < 4; i++) begin
                if (dcache_sdram_wstrb[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= dcache_sdram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_complete <= 1'b0;
            r_rdata    <= '0;
            r_raddress <= '0;
            r_lat_cnt  <= '0;
            r_beat     <= '0;
            r_base     <= '0;
            r_burst    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rvalid   <= 1'b0;
                    r_complete <= 1'b0;
                    r_ready    <= 1'b1;
                    // A write with burst set is still a single write.
                    if (w_accept && !dcache_sdram_write) begin
                        r_base    <= dcache_sdram_addr & C_WORD_MASK;
                        r_burst   <= dcache_sdram_burst;
                        r_lat_cnt <= C_LAT_INIT;
                        r_beat    <= 4'd0;
                        r_ready   <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_rvalid   <= 1'b1;
                        r_raddress <= w_beat_addr;
                        r_rdata    <= r_mem[w_beat_idx];
                        r_beat     <= 4'd0;
                        r_complete <= !r_burst;
                        r_state    <= S_BURST;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end

                S_BURST: begin
                    if (r_complete) begin
                        // Last beat has been shown; hand the port back.
                        r_rvalid   <= 1'b0;
                        r_complete <= 1'b0;
                        r_ready    <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_rvalid   <= 1'b1;
                        r_raddress <= w_beat_addr;
                        r_rdata    <= r_mem[w_beat_idx];
                        r_beat     <= w_beat_sel;
                        r_complete <= (w_beat_sel == C_LAST_BEAT);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dcache_sdram_ready    = r_ready;
    assign dcache_sdram_rvalid   = r_rvalid;
    assign dcache_sdram_rdata    = r_rdata;
    assign dcache_sdram_raddress = r_raddress;
    assign dcache_sdram_complete = r_complete;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdram_responder
// Description : Self-checking bench for sdram_responder. A transaction-level
//               model predicts ready and every read beat from the protocol
//               rules; a negedge compare process checks the DUT each cycle.
//               Directed sequences add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_responder;

    localparam int AW    = 26;
    localparam int MW    = 16384;
    localparam int RL    = 3;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dcache_sdram_ready;
    logic          dcache_sdram_request = 1'b0;
    logic [AW-1:0] dcache_sdram_addr = '0;
    logic          dcache_sdram_write = 1'b0;
    logic          dcache_sdram_burst = 1'b0;
    logic [3:0]    dcache_sdram_wstrb = 4'h0;
    logic [31:0]   dcache_sdram_wdata = 32'h0;
    logic          dcache_sdram_rvalid;
    logic [31:0]   dcache_sdram_rdata;
    logic [AW-1:0] dcache_sdram_raddress;
    logic          dcache_sdram_complete;

    sdram_responder #(
        .ADDR_WIDTH   (AW),
        .MEM_WORDS    (MW),
        .READ_LATENCY (RL),
        .BURST_LEN    (16)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .dcache_sdram_ready    (dcache_sdram_ready),
        .dcache_sdram_request  (dcache_sdram_request),
        .dcache_sdram_addr     (dcache_sdram_addr),
        .dcache_sdram_write    (dcache_sdram_write),
        .dcache_sdram_burst    (dcache_sdram_burst),
        .dcache_sdram_wstrb    (dcache_sdram_wstrb),
        .dcache_sdram_wdata    (dcache_sdram_wdata),
        .dcache_sdram_rvalid   (dcache_sdram_rvalid),
        .dcache_sdram_rdata    (dcache_sdram_rdata),
        .dcache_sdram_raddress (dcache_sdram_raddress),
        .dcache_sdram_complete (dcache_sdram_complete)
    );

    always #5 clock = ~clock;

    int ecnt = 0;
    always @(posedge clock) ecnt <= ecnt + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, ecnt);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    typedef struct {
        int            e;   // cycle count at which the beat is visible
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          c;
    } beat_t;

    beat_t         q[$];
    logic [31:0]   mmem [int];
    int            ready_from = NEVER;
    logic          prev_rst   = 1'b0;
    logic [31:0]   last_d     = 32'h0;
    logic [AW-1:0] last_a     = '0;

    function automatic int widx(input logic [AW-1:0] a);
        return (int'(a) / 4) % MW;
    endfunction

    // Called in the cycle numbered n for a request that is taken at edge n+1.
    task automatic model_accept(input int n);
        logic [AW-1:0] base;
        logic [31:0]   w;
        beat_t         b;
        int            nb, off, idx;
        base = dcache_sdram_addr & ~AW'(3);
        if (dcache_sdram_write) begin
            idx = widx(base);
            w   = mmem.exists(idx) ? mmem[idx] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (dcache_sdram_wstrb[i]) w[8*i +: 8] = dcache_sdram_wdata[8*i +: 8];
            mmem[idx] = w;
        end else begin
            nb = dcache_sdram_burst ? 16 : 1;
            for (int k = 0; k < nb; k++) begin
                off = (int'(base[5:2]) + k) % 16;
                b.a = (base & ~AW'(63)) | AW'(off * 4);
                idx = widx(b.a);
                b.d = mmem.exists(idx) ? mmem[idx] : 32'h0;
                b.e = n + 1 + RL + k;
                b.c = (k == nb - 1);
                q.push_back(b);
            end
            ready_from = n + 1 + RL + nb;
        end
    endtask

    // Compare process
    int   mon_n;
    logic exp_rdy;
    initial begin
        forever begin
            @(negedge clock);
            mon_n = ecnt;
            if (!reset) begin
                chk("rst_ready",    32'(dcache_sdram_ready),    32'h0);
                chk("rst_rvalid",   32'(dcache_sdram_rvalid),   32'h0);
                chk("rst_complete", 32'(dcache_sdram_complete), 32'h0);
                chk("rst_rdata",    dcache_sdram_rdata,         32'h0);
                chk("rst_raddress", 32'(dcache_sdram_raddress), 32'h0);
                q.delete();
                last_d     = 32'h0;
                last_a     = '0;
                ready_from = NEVER;
            end else begin
                if (!prev_rst) ready_from = mon_n + 1;
                exp_rdy = (mon_n >= ready_from);
                chk("ready", 32'(dcache_sdram_ready), 32'(exp_rdy));
                if (q.size() > 0 && q[0].e == mon_n) begin
                    chk("rvalid",   32'(dcache_sdram_rvalid),   32'h1);
                    chk("raddress", 32'(dcache_sdram_raddress), 32'(q[0].a));
                    chk("rdata",    dcache_sdram_rdata,         q[0].d);
                    chk("complete", 32'(dcache_sdram_complete), 32'(q[0].c));
                    last_d = q[0].d;
                    last_a = q[0].a;
                    void'(q.pop_front());
                end else begin
                    chk("idle_rvalid",   32'(dcache_sdram_rvalid),   32'h0);
                    chk("idle_complete", 32'(dcache_sdram_complete), 32'h0);
                    chk("hold_rdata",    dcache_sdram_rdata,         last_d);
                    chk("hold_raddress", 32'(dcache_sdram_raddress), 32'(last_a));
                end
                if (exp_rdy && dcache_sdram_request) model_accept(mon_n);
            end
            prev_rst = reset;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks: called just after a posedge, return 1ns after the
    // accepting edge.
    // ------------------------------------------------------------------
    task automatic handshake();
        bit done = 1'b0;
        dcache_sdram_request = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (dcache_sdram_ready) begin
                @(posedge clock);
                #1;
                done = 1'b1;
            end
        end
        dcache_sdram_request = 1'b0;
        chk("handshake", 32'(done), 32'h1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic bu);
        dcache_sdram_addr  = a;
        dcache_sdram_wdata = d;
        dcache_sdram_wstrb = s;
        dcache_sdram_write = 1'b1;
        dcache_sdram_burst = bu;
        handshake();
        dcache_sdram_write = 1'b0;
        dcache_sdram_burst = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic bu);
        dcache_sdram_addr  = a;
        dcache_sdram_write = 1'b0;
        dcache_sdram_burst = bu;
        handshake();
        dcache_sdram_burst = 1'b0;
    endtask

    task automatic read_single_check(input logic [AW-1:0] a, input logic [31:0] exp);
        do_read(a, 1'b0);
        repeat (RL - 1) @(posedge clock);
        #1;
        chk("lit_pre_rvalid", 32'(dcache_sdram_rvalid), 32'h0);
        @(posedge clock);
        #1;
        chk("lit_rvalid",   32'(dcache_sdram_rvalid),   32'h1);
        chk("lit_complete", 32'(dcache_sdram_complete), 32'h1);
        chk("lit_rdata",    dcache_sdram_rdata,         exp);
        chk("lit_raddress", 32'(dcache_sdram_raddress), 32'(a & ~AW'(3)));
        @(posedge clock);
        #1;
        chk("lit_ready_after", 32'(dcache_sdram_ready), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and release
        repeat (3) @(posedge clock);
        #1;
        chk("lit_ready_in_reset", 32'(dcache_sdram_ready), 32'h0);
        reset = 1'b1;
        #2;
        chk("lit_ready_at_release", 32'(dcache_sdram_ready), 32'h0);
        @(posedge clock);
        #1;
        chk("lit_ready_after_release", 32'(dcache_sdram_ready), 32'h1);

        // Byte-masked write merge
        do_write(26'h1000, 32'hAABBCCDD, 4'b1111, 1'b0);
        do_write(26'h1000, 32'h11223344, 4'b0101, 1'b0);
        read_single_check(26'h1000, 32'hAA22CC44);

        // Wrapping burst
        for (int i = 0; i < 16; i++)
            do_write(AW'(32'h2000 + 4 * i), 32'h2000 + 4 * i, 4'b1111, 1'b0);
        do_read(26'h2024, 1'b1);
        repeat (RL) @(posedge clock);
        #1;
        chk("lit_b0_addr",     32'(dcache_sdram_raddress), 32'h2024);
        chk("lit_b0_data",     dcache_sdram_rdata,         32'h2024);
        chk("lit_b0_complete", 32'(dcache_sdram_complete), 32'h0);
        repeat (15) @(posedge clock);
        #1;
        chk("lit_b15_addr",     32'(dcache_sdram_raddress), 32'h2020);
        chk("lit_b15_complete", 32'(dcache_sdram_complete), 32'h1);
        chk("lit_b15_ready",    32'(dcache_sdram_ready),    32'h0);
        @(posedge clock);
        #1;
        chk("lit_burst_ready_after", 32'(dcache_sdram_ready), 32'h1);

        // Back-to-back writes, then read on the very next cycle
        for (int i = 0; i < 4; i++)
            do_write(AW'(32'h3000 + 4 * i), 32'hC0DE0000 + i, 4'b1111, 1'b0);
        read_single_check(26'h300C, 32'hC0DE0003);
        for (int i = 0; i < 3; i++)
            read_single_check(AW'(32'h3000 + 4 * i), 32'hC0DE0000 + i);

        // Reset in the middle of a burst (beat 5)
        do_read(26'h2024, 1'b1);
        repeat (RL + 5) @(posedge clock);
        #1;
        chk("lit_b5_rvalid", 32'(dcache_sdram_rvalid),   32'h1);
        chk("lit_b5_addr",   32'(dcache_sdram_raddress), 32'h2038);
        reset = 1'b0;
        #1;
        chk("lit_async_rvalid",   32'(dcache_sdram_rvalid),   32'h0);
        chk("lit_async_complete", 32'(dcache_sdram_complete), 32'h0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        read_single_check(26'h3004, 32'hC0DE0001);

        // Address aliasing above the memory depth
        do_write(26'h0000010, 32'hDEADBEEF, 4'b1111, 1'b0);
        read_single_check(26'h0010010, 32'hDEADBEEF);

        // Request held while busy, zero strobe, write with burst set
        do_read(26'h2000, 1'b1);
        do_write(26'h3000, 32'h555555AA, 4'b0001, 1'b0);
        read_single_check(26'h3000, 32'hC0DE00AA);
        do_write(26'h3004, 32'hFFFFFFFF, 4'b0000, 1'b0);
        read_single_check(26'h3004, 32'hC0DE0001);
        do_write(26'h3008, 32'h12345678, 4'b1111, 1'b1);
        read_single_check(26'h3008, 32'h12345678);

        repeat (5) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
